// File: rtl/fifo_pkg.sv
// Shared types for the FIFO write-side arbiter: the FIFO word and the arbiter FSM states.
package fifo_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotating-priority search: returns the first valid requester at or above rr_ptr,
// wrapping modulo NumReq, plus a flag saying whether any requester is valid.
module fifo_rr_pick #(
  parameter int NumReq = 4,
  localparam int IdxW  = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [IdxW-1:0]   pick,
  output logic              any_valid
);

  logic [NumReq-1:0] rot_valid;
  logic [IdxW-1:0]   rot_idx [NumReq];

  // rot_idx[gi] is the requester sitting gi places after rr_ptr.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_rot
    logic [IdxW:0] sum;
    assign sum           = {1'b0, rr_ptr} + (IdxW+1)'(gi);
    assign rot_idx[gi]   = (sum >= (IdxW+1)'(NumReq)) ? IdxW'(sum - (IdxW+1)'(NumReq))
                                                      : IdxW'(sum);
    assign rot_valid[gi] = valid[rot_idx[gi]];
  end

  // Scan from the far end so the nearest valid offset wins.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        pick      = rot_idx[i];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NumReq burst producers.
// A grant stays locked for a whole burst, bounded to MaxBurst accepted beats.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int MaxBurst = 16,
  localparam int IdxW    = $clog2(NumReq),
  localparam int CntW    = $clog2(MaxBurst + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_valid_i,
  output logic [NumReq-1:0]  req_ready_o,
  input  logic [NumReq-1:0]  req_last_i,
  input  word_t [NumReq-1:0] req_data_i,
  output logic               fifo_push_o,
  output word_t              fifo_data_o,
  input  logic               fifo_full_i,
  output logic [IdxW-1:0]    owner_o,
  output logic               busy_o,
  output logic               burst_err_o
);

  arb_state_e      state_reg, state_next;
  logic [IdxW-1:0] owner_reg, owner_next;
  logic [IdxW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CntW-1:0] beat_cnt_reg, beat_cnt_next;
  logic            burst_err_reg, burst_err_next;

  logic [IdxW-1:0] pick;
  logic            any_valid;
  logic            locked;
  logic            push;
  logic            owner_last;
  logic            at_limit;
  logic            rel_beat;
  logic [IdxW-1:0] owner_succ;

  fifo_rr_pick #(
    .NumReq(NumReq)
  ) u_pick (
    .valid     (req_valid_i),
    .rr_ptr    (rr_ptr_reg),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign locked     = (state_reg == LOCKED);
  // A reset cycle never pushes, even if the FSM still shows LOCKED.
  assign push       = locked && !rst_i && !fifo_full_i && req_valid_i[owner_reg];
  assign owner_last = req_last_i[owner_reg];
  assign at_limit   = (beat_cnt_reg == CntW'(MaxBurst - 1));
  assign rel_beat   = push && (owner_last || at_limit);
  assign owner_succ = (owner_reg == IdxW'(NumReq - 1)) ? '0 : owner_reg + IdxW'(1);

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready_o[gi] = locked && !rst_i && !fifo_full_i && (owner_reg == IdxW'(gi));
  end

  assign fifo_push_o = push;
  assign fifo_data_o = locked ? req_data_i[owner_reg] : '0;
  assign owner_o     = locked ? owner_reg : '0;
  assign busy_o      = locked;
  assign burst_err_o = burst_err_reg;

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    burst_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next    = LOCKED;
          owner_next    = pick;
          beat_cnt_next = '0;
        end
      end
      LOCKED: begin
        if (push) begin
          beat_cnt_next = beat_cnt_reg + CntW'(1);
        end
        if (rel_beat) begin
          state_next     = IDLE;
          rr_ptr_next    = owner_succ;
          burst_err_next = !owner_last;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      beat_cnt_reg  <= '0;
      burst_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      burst_err_reg <= burst_err_next;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter sharing one FIFO push port between NumReq requesters.
- Each requester sends bursts of word_t beats (valid/ready, last marks the final beat).
- A grant is locked for the whole burst, so bursts never interleave in the FIFO.
- A beat limit bounds how long one requester can hold the FIFO.
- Sits between producer engines and the fifo block's push side.

Parameters:
- NumReq, 4, number of requesters; minimum 2.
- MaxBurst, 16, maximum accepted beats per grant; minimum 1.
- IdxW, $clog2(NumReq), derived; width of requester index.
- CntW, $clog2(MaxBurst+1), derived; beat counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  NumReq  per-requester beat valid.
- req_ready_o  out  NumReq  per-requester beat accepted.
- req_last_i  in  NumReq  per-requester last beat of burst.
- req_data_i  in  NumReq x 32 (word_t array)  per-requester beat data.
- fifo_push_o  out  1  push strobe into FIFO.
- fifo_data_o  out  32 (word_t)  push data.
- fifo_full_i  in  1  FIFO full; no push allowed while high.
- owner_o  out  IdxW  current grant owner; valid only when busy_o=1.
- busy_o  out  1  a grant is locked.
- burst_err_o  out  1  one-cycle pulse on forced release at MaxBurst.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, burst_err_o=0.
  - All outputs are 0 while in IDLE.
  - Reset mid-burst abandons the burst; no push in the reset cycle; the next grant starts from rr_ptr=0.
- State machine: IDLE, LOCKED.
- IDLE:
  - No beats are accepted (req_ready_o all 0).
  - If any req_valid_i is set, pick the first valid index at or above rr_ptr, wrapping modulo NumReq.
  - Next cycle: owner=pick, beat_cnt=0, state=LOCKED.
  - Arbitration costs exactly one bubble cycle per grant.
- LOCKED:
  - req_ready_o[owner] = !fifo_full_i; all other ready bits are 0.
  - fifo_push_o = req_valid_i[owner] && !fifo_full_i.
  - fifo_data_o = req_data_i[owner] (combinational; zero latency).
  - An accepted beat (push=1) increments beat_cnt.
  - Owner valid low, or fifo_full_i high, stalls: counter and state hold, no push.
  - Non-owner valids are ignored and held off; they are not dropped.
- Release: on an accepted beat with req_last_i[owner]=1, or on the accepted beat that makes beat_cnt equal MaxBurst:
  - state becomes IDLE next cycle.
  - rr_ptr becomes (owner+1) mod NumReq.
- Forced release (MaxBurst reached without last):
  - burst_err_o pulses high for exactly the cycle after the release beat.
  - The requester's remaining beats compete again as a new burst.
- Last and MaxBurst on the same beat: normal release, no error.
- MaxBurst=1: every beat releases; a beat with last=0 raises burst_err_o.
- fifo_data_o is don't-care when fifo_push_o=0 (drive 0 in IDLE).
- The block never pushes while fifo_full_i=1, so it cannot overflow the FIFO.

Decomposition:
- fifo_pkg holds:
  - word_t (32-bit logic vector).
  - arb_state_e {IDLE, LOCKED}.
- Sub-module fifo_rr_pick (combinational):
  - inputs: valid vector, rr_ptr.
  - outputs: picked index, any-valid flag.
  - Rotating priority search; verified standalone exhaustively for NumReq=4.
- Top: FSM, owner/rr_ptr/beat_cnt registers, output muxing.

Test Plan:
- Single burst: req 2 sends 3 beats 0xA0,0xA1,0xA2 (last on 0xA2), FIFO never full.
  - owner_o=2 one cycle after valid.
  - 3 consecutive pushes with data in order.
  - busy_o drops the cycle after 0xA2.
  - rr_ptr=3.
- Round-robin: all 4 requesters hold 1-beat bursts continuously from reset.
  - Grant order 0,1,2,3,0.
  - Exactly one idle cycle between pushes.
  - No push from any non-owner.
- Backpressure: req 1 sends 4 beats; fifo_full_i high for 2 cycles after beat 2.
  - push=0 and req_ready_o[1]=0 during full.
  - beat_cnt holds at 2.
  - Beats 3 and 4 pushed after full drops; data unaltered.
- Forced release: MaxBurst=16, req 0 sends 20 beats with last only on beat 20, req 3 valid throughout.
  - Release after beat 16.
  - burst_err_o high for exactly 1 cycle.
  - Next owner is 3, then req 0 resumes with beats 17..20.
- Reset mid-burst: rst_i asserted after beat 2 of a 5-beat burst from req 1.
  - No push in the reset cycle.
  - busy_o=0, owner_o=0.
  - Next arbitration with req 1 and req 3 both valid grants req 1 (rr_ptr=0, first valid at or above 0).
- Last equals MaxBurst: MaxBurst=4, req 2 sends 4 beats with last on beat 4.
  - Release with burst_err_o staying 0.
